// File: rtl/seq_pattern_gen_pkg.sv
// ============================================================================
// Module      : seq_pattern_gen_pkg
// Description : Shared state encoding, default widths and configuration check
//               for the serial pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int c_DEF_PAT_W = 8;
    localparam int c_DEF_LEN_W = 4;

    // The length field must be able to express every bit position of the pattern.
    function automatic bit len_fits(input int pat_w, input int len_w);
        return (1 << len_w) > pat_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_tick_div.sv
// ============================================================================
// Module      : bit_tick_div
// Description : Bit-period divider; tick is high on the last cycle of each
//               DIV-cycle period. clear holds the period at its first cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_tick_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    generate
        if (DIV <= 1) begin : g_div1
            logic w_unused;
            assign w_unused = ^{clk, rst, clear};
            assign tick     = 1'b1;
        end else begin : g_divn
            localparam int c_CW = $clog2(DIV);
            logic [c_CW-1:0] r_cnt;

            // Down-counter reloads on every period boundary, so it never wraps.
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_cnt <= c_CW'(DIV - 1);
                end else if (r_cnt == '0) begin
                    r_cnt <= c_CW'(DIV - 1);
                end else begin
                    r_cnt <= r_cnt - c_CW'(1);
                end
            end

            assign tick = (r_cnt == '0);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module      : seq_pattern_gen
// Description : MSB-first serial pattern transmitter with start/busy/done
//               handshake and running ones count. Optional back-to-back
//               frame repeat enabled by macro SEQ_GEN_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int PAT_W = c_DEF_PAT_W,
    parameter int LEN_W = c_DEF_LEN_W,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] length,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic             rpt,
`endif
    output logic             seq,
    output logic             seq_valid,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] ones_cnt
);

    localparam int c_IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    generate
        if (!len_fits(PAT_W, LEN_W)) begin : g_cfg_err
            $error("seq_pattern_gen: LEN_W too small for PAT_W");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] r_ones;
    logic [LEN_W-1:0] w_len;
    logic             r_first;
    logic             r_rpt_done;
    logic             w_tick;
    logic             w_bit;
    logic             w_last;
    logic             w_rpt;

`ifdef SEQ_GEN_REPEAT_EN
    assign w_rpt = rpt;
`else
    assign w_rpt = 1'b0;
`endif

    bit_tick_div #(
        .DIV   (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (r_state != SHIFT),
        .tick  (w_tick)
    );

    assign w_len  = (length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : length;
    assign w_bit  = r_pat[r_idx[c_IW-1:0]];
    assign w_last = (r_state == SHIFT) && w_tick && (r_idx == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (length == '0) ? DONE : SHIFT;
            SHIFT:   if (w_last) w_next = w_rpt ? SHIFT : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pat      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_ones     <= '0;
            r_first    <= 1'b0;
            r_rpt_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rpt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ones <= '0;
                        if (length != '0) begin
                            r_pat   <= pattern;
                            r_len   <= w_len;
                            r_idx   <= w_len - LEN_W'(1);
                            r_first <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Count a 1-bit once, on the first cycle it is presented.
                    r_first <= w_tick;
                    if (r_first && w_bit) r_ones <= r_ones + LEN_W'(1);
                    if (w_tick) begin
                        if (r_idx != '0) begin
                            r_idx <= r_idx - LEN_W'(1);
                        end else if (w_rpt) begin
                            r_idx      <= r_len - LEN_W'(1);
                            r_ones     <= '0;
                            r_rpt_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign seq       = (r_state == SHIFT) && w_bit;
    assign seq_valid = (r_state == SHIFT);
    assign busy      = (r_state == SHIFT);
    assign done      = (r_state == DONE) || r_rpt_done;
    assign ones_cnt  = r_ones;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
// ============================================================================
// Module      : tb_seq_pattern_gen
// Description : Self-checking bench for seq_pattern_gen (DIV=1 and DIV=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start_3;
    logic [7:0] pattern, pattern_3;
    logic [3:0] length, length_3;
    logic       seq, seq_valid, busy, done;
    logic       seq_3, seq_valid_3, busy_3, done_3;
    logic [3:0] ones_cnt, ones_cnt_3;
`ifdef SEQ_GEN_REPEAT_EN
    logic       rpt;
    logic       rpt_3 = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic sb_q[$];
    logic sb_exp;

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(8), .LEN_W(4), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .length(length),
`ifdef SEQ_GEN_REPEAT_EN
        .rpt(rpt),
`endif
        .seq(seq), .seq_valid(seq_valid), .busy(busy), .done(done), .ones_cnt(ones_cnt)
    );

    seq_pattern_gen #(.PAT_W(8), .LEN_W(4), .DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_3), .pattern(pattern_3), .length(length_3),
`ifdef SEQ_GEN_REPEAT_EN
        .rpt(rpt_3),
`endif
        .seq(seq_3), .seq_valid(seq_valid_3), .busy(busy_3), .done(done_3),
        .ones_cnt(ones_cnt_3)
    );

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        int         nbits;
        int         ones;
        string      name;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Scoreboard: every valid serial bit must match the next queued model bit.
    always @(negedge clk) begin
        if (seq_valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_extra_bit: got seq=%0b expected no valid bit", seq);
            end else begin
                sb_exp = sb_q.pop_front();
                if (seq !== sb_exp) begin
                    n_errors++;
                    $display("FAIL sb_bit: got seq=%0b expected %0b", seq, sb_exp);
                end
            end
        end
    end

    task automatic push_bits(input logic [7:0] p, input logic [3:0] len);
        int l;
        l = (len > 4'd8) ? 8 : int'(len);
        for (int i = l - 1; i >= 0; i--) sb_q.push_back(p[i]);
    endtask

    // Entered and left on a negedge with the DUT in IDLE.
    task automatic run_frame(input vec_t v);
        start = 1'b1; pattern = v.pat; length = v.len;
        push_bits(v.pat, v.len);
        @(negedge clk);
        start = 1'b0; pattern = ~v.pat; length = 4'd1;
        for (int k = 1; k <= v.nbits; k++) begin
            chk({v.name, " busy"}, {31'd0, busy}, 1);
            chk({v.name, " done_early"}, {31'd0, done}, 0);
            @(negedge clk);
        end
        chk({v.name, " done"}, {31'd0, done}, 1);
        chk({v.name, " valid_off"}, {31'd0, seq_valid}, 0);
        chk({v.name, " ones"}, {28'd0, ones_cnt}, v.ones);
        chk({v.name, " sb_empty"}, sb_q.size(), 0);
        @(negedge clk);
        chk({v.name, " done_once"}, {31'd0, done}, 0);
        chk({v.name, " ones_hold"}, {28'd0, ones_cnt}, v.ones);
    endtask

    initial begin
        int ndone;
        int nvalid;

        vecs[0] = '{8'b1011_0010, 4'd8,  8, 4, "base8"};
        vecs[1] = '{8'hFF,        4'd12, 8, 8, "len12_clamp"};
        vecs[2] = '{8'h0F,        4'd3,  3, 3, "len3"};
        vecs[3] = '{8'h80,        4'd1,  1, 0, "len1"};
        vecs[4] = '{8'hA5,        4'd5,  5, 2, "len5"};
        vecs[5] = '{8'h5A,        4'd0,  0, 0, "len0"};

        rst = 1'b1; start = 1'b0; pattern = '0; length = '0;
        start_3 = 1'b0; pattern_3 = '0; length_3 = '0;
`ifdef SEQ_GEN_REPEAT_EN
        rpt = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst seq", {31'd0, seq}, 0);
        chk("rst seq_valid", {31'd0, seq_valid}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst done", {31'd0, done}, 0);
        chk("rst ones_cnt", {28'd0, ones_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_frame(vecs[i]);

        // start pulses mid-frame are ignored; next start right after done.
        start = 1'b1; pattern = 8'b1011_0010; length = 4'd8;
        push_bits(8'b1011_0010, 4'd8);
        ndone = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 5);
            if (done === 1'b1) ndone++;
        end
        chk("ign_start done_c9", {31'd0, done}, 1);
        start = 1'b0;
        @(negedge clk);
        chk("ign_start single_done", ndone, 1);
        chk("ign_start idle_c10", {31'd0, seq_valid}, 0);
        start = 1'b1; pattern = 8'h01; length = 4'd1;
        push_bits(8'h01, 4'd1);
        @(negedge clk);
        start = 1'b0;
        chk("restart valid", {31'd0, seq_valid}, 1);
        @(negedge clk);
        chk("restart done", {31'd0, done}, 1);
        chk("restart ones", {28'd0, ones_cnt}, 1);
        @(negedge clk);

        // DIV=3: three 3-cycle bits of 1.
        start_3 = 1'b1; pattern_3 = 8'b0000_0111; length_3 = 4'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_3 = 1'b0;
            chk($sformatf("div3 valid c%0d", k), {31'd0, seq_valid_3}, (k <= 9) ? 1 : 0);
            chk($sformatf("div3 seq c%0d", k), {31'd0, seq_3}, (k <= 9) ? 1 : 0);
            chk($sformatf("div3 done c%0d", k), {31'd0, done_3}, (k == 10) ? 1 : 0);
            if (k == 2) chk("div3 ones c2", {28'd0, ones_cnt_3}, 1);
            if (k == 4) chk("div3 ones c4", {28'd0, ones_cnt_3}, 1);
            if (k == 5) chk("div3 ones c5", {28'd0, ones_cnt_3}, 2);
            if (k == 10) chk("div3 ones c10", {28'd0, ones_cnt_3}, 3);
        end
        @(negedge clk);
        chk("div3 busy_off", {31'd0, busy_3}, 0);

`ifdef SEQ_GEN_REPEAT_EN
        // Two back-to-back frames, then a normal finish.
        start = 1'b1; pattern = 8'b1000_0001; length = 4'd8; rpt = 1'b1;
        push_bits(8'b1000_0001, 4'd8);
        push_bits(8'b1000_0001, 4'd8);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 9) rpt = 1'b0;
            chk($sformatf("rpt valid c%0d", k), {31'd0, seq_valid}, (k <= 16) ? 1 : 0);
            chk($sformatf("rpt done c%0d", k), {31'd0, done}, (k == 9 || k == 17) ? 1 : 0);
            if (k == 17) chk("rpt ones c17", {28'd0, ones_cnt}, 2);
            if (k == 18) chk("rpt idle c18", {31'd0, busy}, 0);
        end
`endif

        // Reset in cycle 4 of an 8-bit frame aborts it with no done pulse.
        start = 1'b1; pattern = 8'b1011_0010; length = 4'd8;
        push_bits(8'b1011_0010, 4'd8);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        chk("abort seq", {31'd0, seq}, 0);
        chk("abort seq_valid", {31'd0, seq_valid}, 0);
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort done", {31'd0, done}, 0);
        chk("abort ones_cnt", {28'd0, ones_cnt}, 0);
        ndone = 0; nvalid = 0;
        for (int k = 6; k <= 14; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (seq_valid === 1'b1) nvalid++;
        end
        chk("abort no_done", ndone, 0);
        chk("abort no_valid", nvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial bit-stream transmitter that drives the single-bit `seq` input of the team's sequence-detector FSMs.
- Captures a parallel pattern and a bit count, then shifts the pattern out MSB-first, one bit per DIV clock cycles.
- Start/busy/done handshake plus a running count of 1-bits sent, so a bench or controller can predict the detector's response.
- Sits upstream of the detector: `seq_pattern_gen.seq` connects to the detector's `seq`.

Parameters:
- PAT_W, 8: pattern register width in bits.
- LEN_W, 4: width of the length and ones-count fields; must satisfy 2^LEN_W > PAT_W.
- DIV, 1: clock cycles each bit is held; must be >= 1.

Ports:
- clk  input  1  single system clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to transmit; sampled only in IDLE.
- pattern  input  PAT_W  bits to send; captured on the accepted start.
- length  input  LEN_W  number of bits to send, from pattern[length-1] down to pattern[0].
- seq  output  1  serial data bit.
- seq_valid  output  1  high while seq carries a pattern bit.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse at frame end.
- ones_cnt  output  LEN_W  number of 1-bits sent so far in the current or last frame.

Behaviour:
- Reset: synchronous, active-high; one clock; reset is synchronous and active-high (clk, rst). On rst, every output is 0: seq, seq_valid, busy, done, ones_cnt. State goes to IDLE and the internal registers clear.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - If start=1 and length!=0: capture pattern and the effective length L = min(length, PAT_W), clear ones_cnt, go to SHIFT.
  - If start=1 and length==0: go directly to DONE; no bits are sent and ones_cnt is cleared.
  - Otherwise remain in IDLE with seq=0.
- SHIFT:
  - Bit index i starts at L-1 and decrements to 0. seq = captured[i]; seq_valid=1; busy=1.
  - Each bit is held for exactly DIV cycles, timed by the tick divider.
  - ones_cnt increments by 1 in the cycle after a bit equal to 1 is first presented, so it is final by the DONE cycle.
  - After bit 0 completes its DIV cycles, go to DONE.
- DONE: lasts one cycle. done=1, busy=0, seq_valid=0, seq=0. Next state is IDLE.
- Latency:
  - start accepted in cycle N gives the first seq_valid in cycle N+1.
  - Last valid bit ends in cycle N+L*DIV; done pulses in cycle N+L*DIV+1.
  - The earliest next start is accepted in cycle N+L*DIV+2.
- start while busy or in DONE is ignored, not queued.
- pattern and length changing mid-frame have no effect.
- rst mid-frame aborts immediately: next cycle all outputs are 0, no done pulse, state IDLE.
- ones_cnt holds its value in IDLE until the next accepted start.
- Bit index and divider counters must not wrap: the index stops at 0 and the divider reloads to DIV-1 on each bit boundary.

Optional Feature:
- Macro SEQ_GEN_REPEAT_EN adds input port `rpt` (1 bit).
- With the macro, `rpt` is sampled on the last DIV cycle of bit 0:
  - rpt=1: done pulses for one cycle concurrently with the first bit of the next frame, and the captured pattern and L are reused with no gap. busy and seq_valid stay high, and ones_cnt restarts from 0, or from 1 if the new first bit is 1.
  - rpt=0: normal DONE/IDLE sequence.
- Without the macro, the port does not exist and behaviour is single-shot as above.

Decomposition:
- Shared header `seq_gen_defs.vh` holds:
  - state localparams IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - default PAT_W and LEN_W;
  - a max-length check constant.
- One sub-module, `bit_tick_div`: parameter DIV, inputs clk, rst, clear; output tick (high on the last cycle of each DIV-cycle bit period). The DIV=1 case degenerates to tick=1 constantly.

Test Plan:
- DIV=1, pattern=8'b1011_0010, length=8, start in cycle 0 -> seq=1,0,1,1,0,0,1,0 in cycles 1..8 with seq_valid=1; done=1 in cycle 9; ones_cnt=4.
- DIV=3, pattern=8'b0000_0111, length=3 -> seq=1 for cycles 1..9 in three 3-cycle bits; done in cycle 10; ones_cnt=3; the downstream detector's dout rises after the third bit.
- length=0 with start -> no seq_valid; done in cycle 1; ones_cnt=0. length=12 with PAT_W=8 -> exactly 8 bits sent.
- start pulsed in cycles 3 and 5 during an 8-bit frame -> ignored; a single done in cycle 9; a new start in cycle 10 is accepted.
- rst asserted in cycle 4 of an 8-bit frame -> in cycle 5 seq, seq_valid, busy, done and ones_cnt are 0; no done pulse follows.
- SEQ_GEN_REPEAT_EN, rpt=1, pattern=8'b1000_0001, length=8 -> continuous stream 1000_0001_1000_0001 with done pulses in cycles 9 and 17. rpt=0 at the end of the second frame -> IDLE in cycle 18.
